ula_final_alu: RTL and testbench

- 8-bit registered arithmetic/logic unit (ULA) with a 9-bit result register.
- Combinational operation selected by a 3-bit opcode; the result is captured on the rising clock edge when enabled.
- Asynchronous clear and preset act on the result register.
- Leaf datapath block, driven directly by control logic.

---
 rtl/ula_final_alu.sv | 57 +++++
 tb/tb_ula_final_alu.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/ula_final_alu.sv
// Registered 8-bit arithmetic/logic unit with a WIDTH+1 bit result register.
// The result register has an asynchronous clear (CLR) and preset (PR); clear wins.
module ula_final_alu #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             CLR,
  input  logic             PR,
  input  logic             EN,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       OPCODE,
  output logic [WIDTH:0]   s
);

  logic [WIDTH:0] a_ext_s;
  logic [WIDTH:0] b_ext_s;
  logic [WIDTH:0] f_s;
  logic           pset_s;

  assign a_ext_s = {1'b0, A};
  assign b_ext_s = {1'b0, B};

  // Preset is only active while clear is released, so releasing CLR with PR
  // still low raises pset_s and re-presets the register.
  assign pset_s = CLR & ~PR;

  // Operation select; subtraction wraps modulo 2^(WIDTH+1) so the top bit is the borrow.
  always_comb begin
    f_s = '0;
    case (OPCODE)
      3'b000:  f_s = a_ext_s;
      3'b001:  f_s = a_ext_s + b_ext_s;
      3'b010:  f_s = a_ext_s - b_ext_s;
      3'b011:  f_s = {1'b0, A & B};
      3'b100:  f_s = {1'b0, A | B};
      3'b101:  f_s = {1'b0, A ^ B};
      3'b110:  f_s = {1'b0, ~A};
      3'b111:  f_s = {1'b0, ~B};
      default: f_s = '0;
    endcase
  end

  // Result register with asynchronous clear/preset and synchronous load enable.
  always_ff @(posedge clk or negedge CLR or posedge pset_s) begin
    if (!CLR) begin
      s <= '0;
    end else if (pset_s) begin
      s <= '1;
    end else if (EN) begin
      s <= f_s;
    end else begin
      s <= s;
    end
  end

endmodule

// File: tb/tb_ula_final_alu.sv
// Directed self-checking bench for ula_final_alu: reset/preset behaviour,
// every opcode, load enable and asynchronous clear/preset between edges.
module tb_ula_final_alu;

  logic       clk;
  logic       CLR;
  logic       PR;
  logic       EN;
  logic [7:0] A;
  logic [7:0] B;
  logic [2:0] OPCODE;
  logic [8:0] s;

  int total = 0;
  int bad   = 0;

  ula_final_alu #(.WIDTH(8)) dut (
    .clk    (clk),
    .CLR    (CLR),
    .PR     (PR),
    .EN     (EN),
    .A      (A),
    .B      (B),
    .OPCODE (OPCODE),
    .s      (s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    total = total + 1;
    if (obs !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got 0x%03h expected 0x%03h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Drive operands on the falling edge, then step just past the next rising edge.
  task automatic load(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    @(negedge clk);
    A = a;
    B = b;
    OPCODE = op;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    string      tag;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
    logic [8:0] exp;
  } vec_t;

  vec_t vecs[$];

  initial begin
    CLR = 1'b0;
    PR = 1'b1;
    EN = 1'b1;
    A = 8'h00;
    B = 8'h00;
    OPCODE = 3'b000;

    #2;
    check_eq("reset_no_edge", s, 9'h000);
    A = 8'h12;
    B = 8'h34;
    OPCODE = 3'b001;
    @(posedge clk);
    @(posedge clk);
    #1;
    check_eq("reset_hold", s, 9'h000);

    @(negedge clk);
    CLR = 1'b1;
    load(8'd4, 8'd3, 3'b001);
    check_eq("add_after_release", s, 9'h007);
    #2;
    A = 'x;
    B = 'x;
    OPCODE = 'x;
    #1;
    check_eq("x_inputs_hold", s, 9'h007);

    vecs.push_back('{"sub_pos",  8'h08, 8'h02, 3'b010, 9'h006});
    vecs.push_back('{"sub_neg",  8'h02, 8'h08, 3'b010, 9'h1FA});
    vecs.push_back('{"add_cout", 8'hFF, 8'h01, 3'b001, 9'h100});
    vecs.push_back('{"sub_zero", 8'h55, 8'h55, 3'b010, 9'h000});
    vecs.push_back('{"and",      8'hAA, 8'hCC, 3'b011, 9'h088});
    vecs.push_back('{"or",       8'hAA, 8'hCC, 3'b100, 9'h0EE});
    vecs.push_back('{"xor",      8'hAA, 8'hCC, 3'b101, 9'h066});
    vecs.push_back('{"not_a",    8'hAA, 8'hCC, 3'b110, 9'h055});
    vecs.push_back('{"not_b",    8'hAA, 8'hCC, 3'b111, 9'h033});
    vecs.push_back('{"pass_a",   8'hAA, 8'hCC, 3'b000, 9'h0AA});
    vecs.push_back('{"add_max",  8'hFF, 8'hFF, 3'b001, 9'h1FE});
    foreach (vecs[i]) begin
      load(vecs[i].a, vecs[i].b, vecs[i].op);
      check_eq(vecs[i].tag, s, vecs[i].exp);
    end

    load(8'd4, 8'd3, 3'b001);
    check_eq("en_preload", s, 9'h007);
    @(negedge clk);
    EN = 1'b0;
    for (int k = 0; k < 3; k++) begin
      load(8'h10 + 8'(k), 8'h20, 3'(k + 2));
      check_eq("en_low_hold", s, 9'h007);
    end
    @(negedge clk);
    EN = 1'b1;
    load(8'hAA, 8'hCC, 3'b100);
    check_eq("en_reload", s, 9'h0EE);

    #2;
    CLR = 1'b0;
    #1;
    check_eq("clr_mid_cycle", s, 9'h000);
    #1;
    CLR = 1'b1;
    @(posedge clk);
    #1;
    check_eq("clr_reload", s, 9'h0EE);

    #2;
    PR = 1'b0;
    #1;
    check_eq("pr_mid_cycle", s, 9'h1FF);
    @(posedge clk);
    #1;
    check_eq("pr_hold_over_edge", s, 9'h1FF);
    CLR = 1'b0;
    #1;
    check_eq("clr_beats_pr", s, 9'h000);
    #1;
    CLR = 1'b1;
    #1;
    check_eq("clr_release_pr_low", s, 9'h1FF);
    PR = 1'b1;
    #1;
    check_eq("pr_release_hold", s, 9'h1FF);
    @(posedge clk);
    #1;
    check_eq("pr_reload", s, 9'h0EE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
